// File: rtl/led_pkg.sv
// led_pkg: constants shared by the LF-clocked LED blocks.
//   - FSM state encoding for the blink scheduler (IDLE/ON/OFF/GAP).
//   - Default half-period divider for a ~10 kHz oscillator (~0.5 s per phase).
package led_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ON   = ST_ON,
        S_OFF  = ST_OFF,
        S_GAP  = ST_GAP
    } led_state_e;

    // Half-period = LED_TICK_DIV+1 cycles of the LF clock.
    localparam int LED_TICK_DIV = 5200;

endpackage

// File: rtl/led_blink_sched_if.sv
// led_blink_sched_if: request/grant handshake between status sources and
// the LED scheduler.
//   req      one level request per requester
//   req_cnt  blink count, requester i uses bits [i*CNT_W +: CNT_W]
//   grant    one-hot pulse when a request is accepted
//   done     one-hot pulse when the granted burst ends
// master = requester side, slave = scheduler side.
interface led_blink_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_cnt;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;

    modport master (output req, output req_cnt, input grant, input done);
    modport slave  (input req, input req_cnt, output grant, output done);
endinterface

// File: rtl/led_tick_gen.sv
// led_tick_gen: phase timer for the LED scheduler.
//   clk, rst_n  LF clock, async active-low reset
//   clr         restart the phase (asserted on every FSM state change)
//   tick        high while the counter sits at TICK_DIV; counter then wraps
// Each phase therefore lasts exactly TICK_DIV+1 cycles.
module led_tick_gen #(
    parameter int TICK_DIV = led_pkg::LED_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int TW = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);

    logic [TW-1:0] cnt;

    assign tick = (cnt == TW'(TICK_DIV));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + TW'(1);
    end
endmodule

// File: rtl/led_blink_sched.sv
// led_blink_sched: round-robin sharing of one LED between NUM_REQ requesters.
// A granted requester gets req_cnt ON/OFF blinks, followed by GAP_TICKS OFF
// phases so consecutive bursts stay distinguishable.
//   clk, rst_n  LF oscillator clock, async active-low reset
//   bus         slave side of the req/req_cnt/grant/done handshake
//   busy        high in any state other than IDLE
//   led         registered LED drive, active high
module led_blink_sched
    import led_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int CNT_W     = 4,
    parameter int TICK_DIV  = LED_TICK_DIV,
    parameter int GAP_TICKS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    led_blink_sched_if.slave   bus,
    output logic               busy,
    output logic               led
);
    localparam int IDX_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    led_state_e         state, state_d;
    logic [CNT_W-1:0]   rem, rem_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [IDX_W-1:0]   rr, rr_d;
    logic [GAP_W-1:0]   gap_cnt, gap_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               led_q, led_d;
    logic               tick;
    logic               clr;

    logic [CNT_W-1:0]   cnt_arr [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic               found;
    logic [IDX_W-1:0]   pick;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign cnt_arr[i] = bus.req_cnt[i*CNT_W +: CNT_W];
        assign elig[i]    = bus.req[i] && (cnt_arr[i] != '0);
    end

    // Scan from farthest to nearest after rr so the nearest eligible index
    // is the last one written; k == NUM_REQ is rr itself (lowest priority).
    always_comb begin
        int j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(rr) + k) % NUM_REQ;
            if (elig[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end
    end

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    assign clr = (state_d != state);

    always_comb begin
        state_d = state;
        rem_d   = rem;
        owner_d = owner;
        rr_d    = rr;
        gap_d   = gap_cnt;
        grant_d = '0;
        done_d  = '0;
        led_d   = led_q;
        case (state)
            S_IDLE: begin
                led_d = 1'b0;
                if (found) begin
                    grant_d[pick] = 1'b1;
                    rem_d         = cnt_arr[pick];
                    owner_d       = pick;
                    rr_d          = pick;
                    led_d         = 1'b1;
                    state_d       = S_ON;
                end
            end
            S_ON: begin
                if (tick) begin
                    led_d   = 1'b0;
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (tick) begin
                    if (rem == CNT_W'(1)) begin
                        done_d[owner] = 1'b1;
                        gap_d         = '0;
                        state_d       = S_GAP;
                    end else begin
                        rem_d   = rem - CNT_W'(1);
                        led_d   = 1'b1;
                        state_d = S_ON;
                    end
                end
            end
            S_GAP: begin
                led_d = 1'b0;
                if (tick) begin
                    if (gap_cnt == GAP_W'(GAP_TICKS - 1))
                        state_d = S_IDLE;
                    else
                        gap_d = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                led_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rem     <= '0;
            owner   <= '0;
            rr      <= IDX_W'(NUM_REQ - 1);  // req0 wins the first search
            gap_cnt <= '0;
            grant_q <= '0;
            done_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            state   <= state_d;
            rem     <= rem_d;
            owner   <= owner_d;
            rr      <= rr_d;
            gap_cnt <= gap_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            led_q   <= led_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign led       = led_q;
    assign busy      = (state != S_IDLE);
endmodule

// File: tb/tb_led_blink_sched.sv
// tb_led_blink_sched: directed checks of the LED scheduler with 4-cycle
// phases (TICK_DIV=3), GAP_TICKS=2, four requesters.
module tb_led_blink_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, led;
    int   nvec = 0;
    int   nerr = 0;

    led_blink_sched_if #(.NUM_REQ(4), .CNT_W(4)) bus ();

    led_blink_sched #(.NUM_REQ(4), .CNT_W(4), .TICK_DIV(3), .GAP_TICKS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .led   (led)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.req_cnt = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_cnt(input int i, input logic [3:0] v);
        bus.req_cnt[i*4 +: 4] = v;
    endtask

    task automatic test_reset();
        do_reset();
        set_cnt(1, 4'd3);
        bus.req[1] = 1'b1;
        step();
        bus.req[1] = 1'b0;
        step();
        step();
        nvec++;
        if (led !== 1'b1) begin
            $display("FAIL reset_pre_led got %b want 1", led); nerr++;
        end
        #3 rst_n = 1'b0;
        #1;
        nvec++;
        if ({led, busy, bus.grant, bus.done} !== 10'b0) begin
            $display("FAIL reset_async got led=%b busy=%b grant=%b done=%b want all 0",
                     led, busy, bus.grant, bus.done); nerr++;
        end
        set_cnt(1, 4'd2);
        set_cnt(2, 4'd1);
        bus.req = 4'b0110;
        step();
        nvec++;
        if (bus.grant !== 4'b0000) begin
            $display("FAIL reset_held_grant got %b want 0000", bus.grant); nerr++;
        end
        rst_n = 1'b1;
        step();
        nvec++;
        if (bus.grant !== 4'b0010 || led !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL reset_first_grant got grant=%b led=%b busy=%b want 0010/1/1",
                     bus.grant, led, busy); nerr++;
        end
    endtask

    task automatic test_single_burst();
        logic       exp_led, exp_busy;
        logic [3:0] exp_grant, exp_done;
        do_reset();
        set_cnt(0, 4'd2);
        bus.req[0] = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            step();
            if (e == 1) bus.req[0] = 1'b0;
            exp_led   = (e >= 1 && e <= 4) || (e >= 9 && e <= 12);
            exp_busy  = (e < 25);
            exp_grant = (e == 1)  ? 4'b0001 : 4'b0000;
            exp_done  = (e == 17) ? 4'b0001 : 4'b0000;
            nvec++;
            if (led !== exp_led || busy !== exp_busy ||
                bus.grant !== exp_grant || bus.done !== exp_done) begin
                $display("FAIL single_burst edge %0d got led=%b busy=%b grant=%b done=%b want %b/%b/%b/%b",
                         e, led, busy, bus.grant, bus.done,
                         exp_led, exp_busy, exp_grant, exp_done); nerr++;
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_grant;
        do_reset();
        for (int i = 0; i < 4; i++) set_cnt(i, 4'd1);
        bus.req = 4'b1111;
        for (int e = 1; e <= 52; e++) begin
            step();
            exp_grant = ((e - 1) % 17 == 0) ? (4'b0001 << ((e - 1) / 17)) : 4'b0000;
            nvec++;
            if (bus.grant !== exp_grant) begin
                $display("FAIL contention edge %0d got grant=%b want %b",
                         e, bus.grant, exp_grant); nerr++;
            end
            bus.req = bus.req & ~bus.grant;
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_grant;
        do_reset();
        set_cnt(0, 4'd1);
        bus.req[0] = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            step();
            if (e == 1) begin
                set_cnt(2, 4'd1);
                bus.req[2] = 1'b1;
            end
            exp_grant = (e == 1 || e == 35) ? 4'b0001 :
                        (e == 18)           ? 4'b0100 : 4'b0000;
            nvec++;
            if (bus.grant !== exp_grant) begin
                $display("FAIL fairness edge %0d got grant=%b want %b",
                         e, bus.grant, exp_grant); nerr++;
            end
            if (bus.grant[2]) bus.req[2] = 1'b0;
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        set_cnt(1, 4'd0);
        bus.req = 4'b0010;
        for (int e = 1; e <= 40; e++) begin
            step();
            nvec++;
            if ({bus.grant, bus.done, busy, led} !== 10'b0) begin
                $display("FAIL zero_count edge %0d got grant=%b done=%b busy=%b led=%b want all 0",
                         e, bus.grant, bus.done, busy, led); nerr++;
            end
        end
    endtask

    task automatic test_stability();
        int         rises;
        logic       prev;
        logic [3:0] exp_done;
        rises = 0;
        prev  = 1'b0;
        do_reset();
        set_cnt(0, 4'd2);
        bus.req[0] = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 1) bus.req[0] = 1'b0;
            if (e == 2) set_cnt(0, 4'd5);
            if (led && !prev) rises++;
            prev = led;
            exp_done = (e == 17) ? 4'b0001 : 4'b0000;
            nvec++;
            if (bus.done !== exp_done) begin
                $display("FAIL stability_done edge %0d got %b want %b",
                         e, bus.done, exp_done); nerr++;
            end
        end
        nvec++;
        if (rises != 2) begin
            $display("FAIL stability_blinks got %0d want 2", rises); nerr++;
        end
        nvec++;
        if (busy !== 1'b0) begin
            $display("FAIL stability_idle got busy=%b want 0", busy); nerr++;
        end
    endtask

    initial begin
        bus.req     = '0;
        bus.req_cnt = '0;
        test_reset();
        test_single_burst();
        test_contention();
        test_fairness();
        test_zero_count();
        test_stability();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
